// File: rtl/lc3_seq_ctrl.sv
// LC-3 multi-cycle control sequencer (Moore FSM, all ISA except RTI).
// Latency: 5..9 cycles per instruction with zero-wait memory, +1 per not-ready access cycle.
// Backpressure: access states hold their request until mem_ready; optional timeout halts with bus_err.
module lc3_seq_ctrl #(
   parameter int MEM_WAIT_MAX = 0,
   parameter bit ENABLE_TRAP  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instruction,
   input  logic        n,
   input  logic        z,
   input  logic        p,
   input  logic        mem_ready,
   output logic        marmux_sel,
   output logic [1:0]  pc_sel,
   output logic        addr1_sel,
   output logic [1:0]  addr2_sel,
   output logic [1:0]  bus_sel,
   output logic [1:0]  alu_op,
   output logic        sr1_sel,
   output logic        dr_sel,
   output logic        mdr_sel,
   output logic        mem_r_en,
   output logic        mem_w_en,
   output logic        reg_w_en,
   output logic        ld_pc,
   output logic        ld_ir,
   output logic        ld_cc,
   output logic        ld_mdr,
   output logic        ld_mar,
   output logic        halted,
   output logic        illegal,
   output logic        bus_err
);

   localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
                          OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                          OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                          OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

   localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

   typedef enum logic [4:0] {
      S_RST, S_F0, S_F1, S_F2, S_DEC, S_ALU, S_BR, S_JMP, S_JSR, S_LEA,
      S_AGEN, S_RD, S_IND, S_WB, S_SDAT, S_WR, S_T0, S_T1, S_T2, S_HALT
   } state_t;

   // Where the shared read state goes once its access completes.
   typedef enum logic [1:0] {RET_WB, RET_IND, RET_T2} ret_t;

   state_t          state_q, state_d;
   ret_t            ret_q, ret_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic            illegal_q, illegal_d;
   logic            bus_err_q, bus_err_d;

   logic [3:0]      opcode;
   logic            is_access;
   logic            timeout;
   logic            br_taken;
   logic            base_rel;
   logic            unused_ir;

   assign opcode    = instruction[15:12];
   assign is_access = (state_q == S_F1) || (state_q == S_RD) || (state_q == S_WR);
   // The limit is reached by the MEM_WAIT_MAX-th not-ready cycle; a ready cycle never times out.
   assign timeout   = (MEM_WAIT_MAX > 0) && is_access && !mem_ready &&
                      (32'(wcnt_q) == 32'(MEM_WAIT_MAX - 1));
   assign br_taken  = (n & instruction[11]) | (z & instruction[10]) | (p & instruction[9]);
   assign base_rel  = (opcode == OP_LDR) || (opcode == OP_STR);
   // Operand fields below bit 9 steer the datapath directly; the sequencer never looks at them.
   assign unused_ir = ^instruction[8:0];

   // State, return target, wait counter and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RST;
         ret_q     <= RET_WB;
         wcnt_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         wcnt_q    <= wcnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next-state and Moore strobe decode (mem_ready only gates ld_mdr and the exit of access states).
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      wcnt_d     = wcnt_q;
      marmux_sel = 1'b0;
      pc_sel     = 2'd0;
      addr1_sel  = 1'b0;
      addr2_sel  = 2'd0;
      bus_sel    = 2'd0;
      alu_op     = 2'd0;
      sr1_sel    = 1'b0;
      dr_sel     = 1'b0;
      mdr_sel    = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
      reg_w_en   = 1'b0;
      ld_pc      = 1'b0;
      ld_ir      = 1'b0;
      ld_cc      = 1'b0;
      ld_mdr     = 1'b0;
      ld_mar     = 1'b0;
      halted     = 1'b0;
      illegal    = illegal_q;
      bus_err    = bus_err_q;

      case (state_q)
         S_RST: state_d = S_F0;
         S_F0: begin
            ld_mar  = 1'b1;
            ld_pc   = 1'b1;
            state_d = S_F1;
         end
         S_F1: begin
            mem_r_en = 1'b1;
            ld_mdr   = mem_ready;
            if (mem_ready) state_d = S_F2;
         end
         S_F2: begin
            bus_sel = 2'd3;
            ld_ir   = 1'b1;
            state_d = S_DEC;
         end
         S_DEC: begin
            case (opcode)
               OP_ADD, OP_AND, OP_NOT:                       state_d = S_ALU;
               OP_BR:                                        state_d = S_BR;
               OP_JMP:                                       state_d = S_JMP;
               OP_JSR:                                       state_d = S_JSR;
               OP_LEA:                                       state_d = S_LEA;
               OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = S_AGEN;
               OP_TRAP: begin
                  if (ENABLE_TRAP) begin
                     state_d = S_T0;
                  end else begin
                     state_d   = S_HALT;
                     illegal_d = 1'b1;
                  end
               end
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_ALU: begin
            bus_sel  = 2'd2;
            alu_op   = (opcode == OP_ADD) ? 2'd0 : ((opcode == OP_AND) ? 2'd1 : 2'd2);
            reg_w_en = 1'b1;
            ld_cc    = 1'b1;
            state_d  = S_F0;
         end
         S_BR: begin
            pc_sel    = 2'd1;
            addr2_sel = 2'd2;
            ld_pc     = br_taken;
            state_d   = S_F0;
         end
         S_JMP: begin
            ld_pc     = 1'b1;
            pc_sel    = 2'd1;
            addr1_sel = 1'b1;
            state_d   = S_F0;
         end
         S_JSR: begin
            reg_w_en  = 1'b1;
            dr_sel    = 1'b1;
            ld_pc     = 1'b1;
            pc_sel    = 2'd1;
            addr1_sel = ~instruction[11];
            addr2_sel = instruction[11] ? 2'd3 : 2'd0;
            state_d   = S_F0;
         end
         S_LEA: begin
            marmux_sel = 1'b1;
            addr2_sel  = 2'd2;
            bus_sel    = 2'd1;
            reg_w_en   = 1'b1;
            state_d    = S_F0;
         end
         S_AGEN: begin
            ld_mar     = 1'b1;
            bus_sel    = 2'd1;
            marmux_sel = 1'b1;
            addr1_sel  = base_rel;
            addr2_sel  = base_rel ? 2'd1 : 2'd2;
            ret_d      = ((opcode == OP_LDI) || (opcode == OP_STI)) ? RET_IND : RET_WB;
            state_d    = ((opcode == OP_ST) || (opcode == OP_STR)) ? S_SDAT : S_RD;
         end
         S_RD: begin
            mem_r_en = 1'b1;
            ld_mdr   = mem_ready;
            if (mem_ready) begin
               case (ret_q)
                  RET_IND: state_d = S_IND;
                  RET_T2:  state_d = S_T2;
                  default: state_d = S_WB;
               endcase
            end
         end
         S_IND: begin
            bus_sel = 2'd3;
            ld_mar  = 1'b1;
            if (opcode == OP_LDI) begin
               ret_d   = RET_WB;
               state_d = S_RD;
            end else begin
               state_d = S_SDAT;
            end
         end
         S_WB: begin
            bus_sel  = 2'd3;
            reg_w_en = 1'b1;
            ld_cc    = 1'b1;
            state_d  = S_F0;
         end
         S_SDAT: begin
            sr1_sel = 1'b1;
            alu_op  = 2'd3;
            bus_sel = 2'd2;
            ld_mdr  = 1'b1;
            mdr_sel = 1'b1;
            state_d = S_WR;
         end
         S_WR: begin
            mem_w_en = 1'b1;
            if (mem_ready) state_d = S_F0;
         end
         S_T0: begin
            reg_w_en = 1'b1;
            dr_sel   = 1'b1;
            state_d  = S_T1;
         end
         S_T1: begin
            bus_sel = 2'd1;
            ld_mar  = 1'b1;
            ret_d   = RET_T2;
            state_d = S_RD;
         end
         S_T2: begin
            bus_sel = 2'd3;
            ld_pc   = 1'b1;
            pc_sel  = 2'd2;
            state_d = S_F0;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_RST;
      endcase

      if (timeout) begin
         state_d   = S_HALT;
         bus_err_d = 1'b1;
      end

      // Counter restarts on every state change, so each access begins from zero.
      if (state_d != state_q) begin
         wcnt_d = '0;
      end else if ((MEM_WAIT_MAX > 0) && is_access && !mem_ready) begin
         wcnt_d = wcnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Bench for lc3_seq_ctrl: directed literal checks plus randomized run against a phase-queue model.
// Two instances: default (no timeout, TRAP on) and MEM_WAIT_MAX=4 with TRAP disabled.
// mem_ready is randomized per cycle in the random runs.
module tb_lc3_seq_ctrl;

   typedef struct packed {
      logic       marmux_sel;
      logic [1:0] pc_sel;
      logic       addr1_sel;
      logic [1:0] addr2_sel;
      logic [1:0] bus_sel;
      logic [1:0] alu_op;
      logic       sr1_sel;
      logic       dr_sel;
      logic       mdr_sel;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       reg_w_en;
      logic       ld_pc;
      logic       ld_ir;
      logic       ld_cc;
      logic       ld_mdr;
      logic       ld_mar;
      logic       halted;
      logic       illegal;
      logic       bus_err;
   } out_t;

   typedef enum int {
      P_RST, P_F0, P_F1, P_F2, P_DEC, P_ALU, P_BR, P_JMP, P_JSR, P_LEA, P_AGEN,
      P_RD, P_IND, P_WB, P_SDAT, P_WR, P_T0, P_T1, P_T2, P_HALT
   } phase_t;

   logic        clk;
   logic        rst;
   logic [15:0] instruction;
   logic        n, z, p;
   logic        mem_ready;
   out_t        o [2];

   int          n_chk;
   int          n_fail;
   out_t        trc [32];

   phase_t      ph;
   phase_t      q [$];
   int          wc;
   logic        ill_e, be_e;
   logic [15:0] pend_instr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lc3_seq_ctrl #(
         .MEM_WAIT_MAX(g == 0 ? 0 : 4),
         .ENABLE_TRAP (g == 0)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .instruction(instruction),
         .n          (n),
         .z          (z),
         .p          (p),
         .mem_ready  (mem_ready),
         .marmux_sel (o[g].marmux_sel),
         .pc_sel     (o[g].pc_sel),
         .addr1_sel  (o[g].addr1_sel),
         .addr2_sel  (o[g].addr2_sel),
         .bus_sel    (o[g].bus_sel),
         .alu_op     (o[g].alu_op),
         .sr1_sel    (o[g].sr1_sel),
         .dr_sel     (o[g].dr_sel),
         .mdr_sel    (o[g].mdr_sel),
         .mem_r_en   (o[g].mem_r_en),
         .mem_w_en   (o[g].mem_w_en),
         .reg_w_en   (o[g].reg_w_en),
         .ld_pc      (o[g].ld_pc),
         .ld_ir      (o[g].ld_ir),
         .ld_cc      (o[g].ld_cc),
         .ld_mdr     (o[g].ld_mdr),
         .ld_mar     (o[g].ld_mar),
         .halted     (o[g].halted),
         .illegal    (o[g].illegal),
         .bus_err    (o[g].bus_err)
      );
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Strobes each phase must show, straight from the control table.
   function automatic out_t exp_out(phase_t ph_i, logic [15:0] ir, logic cn, logic cz, logic cp, logic rdy);
      out_t       e;
      logic [3:0] op;
      e  = '0;
      op = ir[15:12];
      case (ph_i)
         P_F0:   begin e.ld_mar = 1'b1; e.ld_pc = 1'b1; end
         P_F1, P_RD: begin e.mem_r_en = 1'b1; e.ld_mdr = rdy; end
         P_F2:   begin e.bus_sel = 2'd3; e.ld_ir = 1'b1; end
         P_ALU:  begin
            e.bus_sel = 2'd2; e.reg_w_en = 1'b1; e.ld_cc = 1'b1;
            e.alu_op = (op == 4'd1) ? 2'd0 : ((op == 4'd5) ? 2'd1 : 2'd2);
         end
         P_BR:   begin
            e.pc_sel = 2'd1; e.addr2_sel = 2'd2;
            e.ld_pc = (cn & ir[11]) | (cz & ir[10]) | (cp & ir[9]);
         end
         P_JMP:  begin e.ld_pc = 1'b1; e.pc_sel = 2'd1; e.addr1_sel = 1'b1; end
         P_JSR:  begin
            e.reg_w_en = 1'b1; e.dr_sel = 1'b1; e.ld_pc = 1'b1; e.pc_sel = 2'd1;
            e.addr1_sel = ~ir[11]; e.addr2_sel = ir[11] ? 2'd3 : 2'd0;
         end
         P_LEA:  begin e.marmux_sel = 1'b1; e.addr2_sel = 2'd2; e.bus_sel = 2'd1; e.reg_w_en = 1'b1; end
         P_AGEN: begin
            e.ld_mar = 1'b1; e.bus_sel = 2'd1; e.marmux_sel = 1'b1;
            if (op == 4'd6 || op == 4'd7) begin e.addr1_sel = 1'b1; e.addr2_sel = 2'd1; end
            else e.addr2_sel = 2'd2;
         end
         P_IND:  begin e.bus_sel = 2'd3; e.ld_mar = 1'b1; end
         P_WB:   begin e.bus_sel = 2'd3; e.reg_w_en = 1'b1; e.ld_cc = 1'b1; end
         P_SDAT: begin e.sr1_sel = 1'b1; e.alu_op = 2'd3; e.bus_sel = 2'd2; e.ld_mdr = 1'b1; e.mdr_sel = 1'b1; end
         P_WR:   e.mem_w_en = 1'b1;
         P_T0:   begin e.reg_w_en = 1'b1; e.dr_sel = 1'b1; end
         P_T1:   begin e.bus_sel = 2'd1; e.ld_mar = 1'b1; end
         P_T2:   begin e.bus_sel = 2'd3; e.ld_pc = 1'b1; e.pc_sel = 2'd2; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Pick the next instruction and queue its whole phase list.
   task automatic start_instr(input bit trap);
      int op;
      op = $urandom_range(0, 15);
      if ((op == 8 || op == 13 || (op == 15 && !trap)) && $urandom_range(0, 9) != 0) op = 5;
      pend_instr = {4'(op), 12'($urandom)};
      q.push_back(P_F0); q.push_back(P_F1); q.push_back(P_F2); q.push_back(P_DEC);
      case (op)
         1, 5, 9: q.push_back(P_ALU);
         0:       q.push_back(P_BR);
         12:      q.push_back(P_JMP);
         4:       q.push_back(P_JSR);
         14:      q.push_back(P_LEA);
         2, 6:    begin q.push_back(P_AGEN); q.push_back(P_RD); q.push_back(P_WB); end
         3, 7:    begin q.push_back(P_AGEN); q.push_back(P_SDAT); q.push_back(P_WR); end
         10:      begin q.push_back(P_AGEN); q.push_back(P_RD); q.push_back(P_IND); q.push_back(P_RD); q.push_back(P_WB); end
         11:      begin q.push_back(P_AGEN); q.push_back(P_RD); q.push_back(P_IND); q.push_back(P_SDAT); q.push_back(P_WR); end
         15:      if (trap) begin q.push_back(P_T0); q.push_back(P_T1); q.push_back(P_RD); q.push_back(P_T2); end
                  else q.push_back(P_HALT);
         default: q.push_back(P_HALT);
      endcase
   endtask

   // Move the model one clock forward given this cycle's mem_ready.
   task automatic advance(input int max, input bit trap);
      bit go;
      go = 1'b0;
      case (ph)
         P_HALT: go = 1'b0;
         P_F1, P_RD, P_WR: begin
            if (mem_ready) go = 1'b1;
            else begin
               wc++;
               if (max > 0 && wc == max) begin ph = P_HALT; be_e = 1'b1; wc = 0; end
            end
         end
         default: go = 1'b1;
      endcase
      if (go) begin
         wc = 0;
         if (q.size() == 0) start_instr(trap);
         ph = q.pop_front();
         if (ph == P_HALT) ill_e = 1'b1;
      end
   endtask

   task automatic model_reset();
      ph = P_RST; q.delete(); wc = 0; ill_e = 1'b0; be_e = 1'b0;
   endtask

   task automatic rand_seg(input int sel, input int max, input bit trap, input int ncyc);
      out_t e;
      int   hcnt;
      hcnt = 0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < ncyc; c++) begin
         mem_ready = ($urandom_range(0, 2) != 0);
         {n, z, p} = 3'($urandom);
         @(negedge clk);
         e = exp_out(ph, instruction, n, z, p, mem_ready);
         e.halted  = (ph == P_HALT);
         e.illegal = ill_e;
         e.bus_err = be_e;
         chk("cycle_outputs", 32'(o[sel]), 32'(e));
         advance(max, trap);
         @(posedge clk); #1;
         instruction = pend_instr;
         if (ph == P_HALT) hcnt++;
         if (hcnt > 3 || $urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1;
            chk("async_reset_outputs", 32'(o[sel]), 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            model_reset();
            hcnt = 0;
         end
      end
   endtask

   // Reset, run one instruction, record 32 cycles of outputs (index 0 = RST cycle).
   // mem_ready stays low for the first w cycles of every access.
   task automatic dir_run(input int sel, input logic [15:0] ir, input logic [2:0] nzp, input int w);
      int acc;
      acc = 0;
      instruction = ir;
      {n, z, p} = nzp;
      mem_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_outputs", 32'(o[sel]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (o[sel].mem_r_en || o[sel].mem_w_en) begin
            acc++;
            mem_ready = (acc > w);
         end else begin
            acc = 0;
            mem_ready = 1'b1;
         end
         @(negedge clk);
         trc[i] = o[sel];
      end
   endtask

   function automatic int next_f0();
      for (int i = 2; i < 32; i++) if (trc[i].ld_mar && trc[i].ld_pc) return i;
      return 99;
   endfunction

   initial begin
      int cnt;
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      instruction = 16'h0;
      {n, z, p} = 3'b000;
      mem_ready = 1'b1;
      pend_instr = 16'h0;

      // ADD R1,R2,R3
      dir_run(0, 16'h1283, 3'b000, 0);
      chk("rst_cycle_zero", 32'(trc[0]), 32'h0);
      chk("add_f0_first", 32'(trc[1].ld_mar & trc[1].ld_pc), 32'h1);
      chk("add_f1_read", 32'(trc[2].mem_r_en), 32'h1);
      chk("add_f2_ldir", 32'({trc[3].ld_ir, trc[3].bus_sel}), 32'h7);
      chk("add_alu_strobes", 32'({trc[5].reg_w_en, trc[5].ld_cc, trc[5].bus_sel, trc[5].alu_op}), 32'h38);
      chk("add_latency", 32'(next_f0() - 1), 32'd5);

      // BRz taken / not taken
      dir_run(0, 16'h0405, 3'b010, 0);
      chk("brz_taken", 32'({trc[5].ld_pc, trc[5].pc_sel, trc[5].addr2_sel}), 32'h16);
      chk("br_latency", 32'(next_f0() - 1), 32'd5);
      dir_run(0, 16'h0405, 3'b101, 0);
      chk("brz_not_taken", 32'({trc[5].ld_pc, trc[5].pc_sel, trc[5].addr2_sel}), 32'h06);

      // LDI with two wait cycles on each of three accesses
      dir_run(0, 16'hA002, 3'b000, 2);
      chk("ldi_latency", 32'(next_f0() - 1), 32'd15);
      cnt = 0;
      for (int i = 2; i < 16; i++) if (trc[i].mem_r_en && !trc[i-1].mem_r_en) cnt++;
      chk("ldi_read_accesses", 32'(cnt), 32'd3);
      chk("ldi_ind_cycle", 32'({trc[11].ld_mar, trc[11].bus_sel}), 32'h7);
      chk("ldi_wb_cycle", 32'({trc[15].ld_cc, trc[15].reg_w_en, trc[15].bus_sel}), 32'hF);

      // STI zero-wait
      dir_run(0, 16'hB001, 3'b000, 0);
      chk("sti_latency", 32'(next_f0() - 1), 32'd9);
      chk("sti_sdat", 32'({trc[8].sr1_sel, trc[8].alu_op, trc[8].mdr_sel, trc[8].ld_mdr, trc[8].bus_sel}), 32'h7E);
      cnt = 0;
      for (int i = 1; i < 10; i++) if (trc[i].mem_w_en) cnt++;
      chk("sti_write_cycles", 32'(cnt), 32'd1);

      // TRAP x25 enabled
      dir_run(0, 16'hF025, 3'b000, 0);
      chk("trap_latency", 32'(next_f0() - 1), 32'd8);
      chk("trap_t0", 32'({trc[5].reg_w_en, trc[5].dr_sel, trc[5].bus_sel}), 32'hC);
      chk("trap_t1", 32'({trc[6].ld_mar, trc[6].bus_sel, trc[6].marmux_sel}), 32'hA);
      chk("trap_t2", 32'({trc[8].ld_pc, trc[8].pc_sel, trc[8].bus_sel}), 32'h1B);

      // TRAP disabled -> illegal halt, sticky
      dir_run(1, 16'hF025, 3'b000, 0);
      chk("trap_off_dec", 32'({trc[4].halted, trc[4].illegal}), 32'h0);
      chk("trap_off_halt", 32'({trc[5].halted, trc[5].illegal, trc[5].bus_err}), 32'h6);
      chk("trap_off_sticky", 32'({trc[20].halted, trc[20].illegal, trc[20].bus_err}), 32'h6);

      // Timeout: 4 not-ready cycles in F1 then HALT with bus_err
      dir_run(1, 16'h1283, 3'b000, 1000);
      cnt = 0;
      for (int i = 0; i < 32; i++) if (trc[i].mem_r_en) cnt++;
      chk("timeout_f1_cycles", 32'(cnt), 32'd4);
      chk("timeout_halt", 32'({trc[6].halted, trc[6].illegal, trc[6].bus_err}), 32'h5);
      rst = 1'b1;
      #1;
      chk("timeout_rst_clears", 32'(o[1]), 32'h0);

      // Ready on the cycle the limit would be hit completes the access
      dir_run(1, 16'h1283, 3'b000, 3);
      chk("ready_at_limit_latency", 32'(next_f0() - 1), 32'd8);
      chk("ready_at_limit_no_err", 32'({trc[8].halted, trc[8].bus_err}), 32'h0);

      // No timeout when MEM_WAIT_MAX = 0
      dir_run(0, 16'h1283, 3'b000, 1000);
      chk("no_timeout_still_reading", 32'({trc[31].mem_r_en, trc[31].bus_err, trc[31].halted}), 32'h4);

      rand_seg(0, 0, 1'b1, 3000);
      rand_seg(1, 4, 1'b0, 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
